// File: rtl/wddl_pkg.sv
// Shared types and default timing for the WDDL phase controller.
package wddl_pkg;

  localparam int unsigned WDDL_PRE_CYC_DEF  = 2;
  localparam int unsigned WDDL_EVAL_CYC_DEF = 2;
  localparam int unsigned WDDL_CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRECH = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } wddl_state_e;

endpackage

// File: rtl/wddl_dual_rail_enc.sv
// Single-rail to dual-rail encoder: {t,f} = {d,~d} when evaluating, {0,0} when precharging.
module wddl_dual_rail_enc #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             prechrg,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] f
);

  assign t = prechrg ? '0 : d;
  assign f = prechrg ? '0 : ~d;

endmodule

// File: rtl/wddl_phase_ctrl.sv
// WDDL precharge/evaluate sequencer with operand/result handshakes.
// Optional rail-integrity checking is enabled by defining WDDL_FAULT_CHECK_EN.
module wddl_phase_ctrl
  import wddl_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned PRE_CYC  = WDDL_PRE_CYC_DEF,
  parameter int unsigned EVAL_CYC = WDDL_EVAL_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             prechrg_o,
  output logic [WIDTH-1:0] a_t_o,
  output logic [WIDTH-1:0] a_f_o,
  output logic [WIDTH-1:0] b_t_o,
  output logic [WIDTH-1:0] b_f_o,
  input  logic [WIDTH-1:0] y_t_i,
  input  logic [WIDTH-1:0] y_f_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             err_o
);

  localparam logic [WDDL_CNT_W-1:0] PreLd  = WDDL_CNT_W'(PRE_CYC - 1);
  localparam logic [WDDL_CNT_W-1:0] EvalLd = WDDL_CNT_W'(EVAL_CYC - 1);

  wddl_state_e           state_q, state_d;
  logic [WDDL_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      a_q, b_q, res_q;
  logic [WIDTH-1:0]      a_t_q, a_f_q, b_t_q, b_f_q;
  logic [WIDTH-1:0]      a_t_d, a_f_d, b_t_d, b_f_d;
  logic                  prechrg_q;
  logic                  enc_prechrg;
  logic                  accept;
  logic                  eval_last;

  assign accept      = in_valid_i && (state_q == IDLE);
  assign eval_last   = (state_q == EVAL) && (cnt_q == '0);
  // Rails are encoded from the next state so the registered pair is glitch-free.
  assign enc_prechrg = (state_d != EVAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = PRECH;
          cnt_d   = PreLd;
        end
      end
      PRECH: begin
        if (cnt_q == '0) begin
          state_d = EVAL;
          cnt_d   = EvalLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  wddl_dual_rail_enc #(.WIDTH(WIDTH)) u_enc_a (
    .d       (a_q),
    .prechrg (enc_prechrg),
    .t       (a_t_d),
    .f       (a_f_d)
  );

  wddl_dual_rail_enc #(.WIDTH(WIDTH)) u_enc_b (
    .d       (b_q),
    .prechrg (enc_prechrg),
    .t       (b_t_d),
    .f       (b_f_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      a_t_q     <= '0;
      a_f_q     <= '0;
      b_t_q     <= '0;
      b_f_q     <= '0;
      prechrg_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prechrg_q <= enc_prechrg;
      a_t_q     <= a_t_d;
      a_f_q     <= a_f_d;
      b_t_q     <= b_t_d;
      b_f_q     <= b_f_d;
      if (accept) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (eval_last) res_q <= y_t_i;
    end
  end

`ifdef WDDL_FAULT_CHECK_EN
  logic pre_last;
  logic err_q;

  assign pre_last = (state_q == PRECH) && (cnt_q == '0);

  // Precharged gates must output 0/0; evaluated gates must output complementary rails.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (pre_last && ((|y_t_i) || (|y_f_i))) begin
      err_q <= 1'b1;
    end else if (eval_last && (|(~(y_t_i ^ y_f_i)))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_y_f;
  assign unused_y_f = ^y_f_i;
  assign err_o      = 1'b0;
`endif

  assign in_ready_o  = (state_q == IDLE) && !rst;
  assign res_valid_o = (state_q == RESP);
  assign res_o       = res_q;
  assign prechrg_o   = prechrg_q;
  assign a_t_o       = a_t_q;
  assign a_f_o       = a_f_q;
  assign b_t_o       = b_t_q;
  assign b_f_o       = b_f_q;

endmodule
